// File: rtl/vic_irq_pkg.sv
// Shared constants, source-mode type and config decode for the vectored interrupt controller.
package vic_irq_pkg;

  localparam int unsigned NUM_SRC   = 31;
  localparam int unsigned ADDR_W    = 5;
  localparam int unsigned CFG_W     = 4;
  localparam logic [ADDR_W-1:0] NO_IRQ = 5'd31;

  localparam int unsigned CFG_LEVEL = 0;
  localparam int unsigned CFG_RISE  = 1;
  localparam int unsigned CFG_FALL  = 2;
  localparam int unsigned CFG_EN    = 3;

  typedef enum logic [1:0] {
    SRC_OFF,
    SRC_LEVEL,
    SRC_EDGE
  } src_mode_e;

  // Level takes precedence over any edge selection.
  function automatic src_mode_e src_mode(input logic [CFG_W-1:0] cfg);
    if (cfg[CFG_LEVEL])
      return SRC_LEVEL;
    else if (cfg[CFG_RISE] || cfg[CFG_FALL])
      return SRC_EDGE;
    else
      return SRC_OFF;
  endfunction

endpackage

// File: rtl/vic_irq_src.sv
// One interrupt source: input sampling, edge detection, mode select and pending flag.
// Optional VIC_IRQ_SYNC_EN inserts a two-flop synchronizer ahead of the sample register.
module vic_irq_src
  import vic_irq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             ext,
  input  logic [CFG_W-1:0] cfg,
  input  logic             ack,
  output logic             pend
);

  logic      samp;
  logic      hist;
  logic      hit;
  logic      pend_nxt;
  src_mode_e mode;

`ifdef VIC_IRQ_SYNC_EN
  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      samp <= 1'b0;
    end else begin
      meta <= ext;
      samp <= meta;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst)
      samp <= 1'b0;
    else
      samp <= ext;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst)
      hist <= 1'b0;
    else
      hist <= samp;
  end

  always_comb begin
    mode     = src_mode(cfg);
    hit      = (cfg[CFG_RISE] & samp & ~hist) | (cfg[CFG_FALL] & ~samp & hist);
    pend_nxt = 1'b0;
    case (mode)
      SRC_LEVEL: pend_nxt = samp;
      // A fresh edge outranks an acknowledge landing in the same cycle.
      SRC_EDGE:  pend_nxt = hit | (pend & ~ack);
      default:   pend_nxt = 1'b0;
    endcase
    if (!cfg[CFG_EN])
      pend_nxt = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst)
      pend <= 1'b0;
    else
      pend <= pend_nxt;
  end

endmodule

// File: rtl/vic_irq_ctrl.sv
// Vectored interrupt controller top: 31 sources, lowest-index priority encoder, acknowledge decode.
// Define VIC_IRQ_SYNC_EN to synchronize asynchronous i_ext inputs (adds one cycle of latency).
module vic_irq_ctrl
  import vic_irq_pkg::*;
(
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NUM_SRC-1:0]       i_ext,
  input  logic [NUM_SRC*CFG_W-1:0] i_reg,
  input  logic                     i_en,
  input  logic                     i_IRQ,
  output logic                     o_IRQ,
  output logic [ADDR_W-1:0]        o_irq_addr
);

  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] ack_vec;
  logic [ADDR_W-1:0]  enc;
  logic               found;

  for (genvar k = 0; k < NUM_SRC; k++) begin : gen_src
    vic_irq_src u_src (
      .clk  (i_clk),
      .rst  (i_rst),
      .ext  (i_ext[k]),
      .cfg  (i_reg[k*CFG_W +: CFG_W]),
      .ack  (ack_vec[k]),
      .pend (pending[k])
    );
  end

  always_comb begin
    enc   = NO_IRQ;
    found = 1'b0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (!found && (((pending >> k) & NUM_SRC'(1)) != '0)) begin
        enc   = ADDR_W'(k);
        found = 1'b1;
      end
    end
  end

  assign o_IRQ      = i_en & (|pending);
  assign o_irq_addr = i_en ? enc : NO_IRQ;

  // Ack only targets the source currently presented to the CPU.
  always_comb begin
    ack_vec = '0;
    if (i_IRQ && o_IRQ)
      ack_vec = NUM_SRC'(1) << o_irq_addr;
  end

endmodule

// File: tb/tb_vic_irq_ctrl.sv
// Directed self-checking bench for vic_irq_ctrl with hand-computed expectations.
module tb_vic_irq_ctrl;

`ifdef VIC_IRQ_SYNC_EN
  localparam int unsigned LAT = 3;
`else
  localparam int unsigned LAT = 2;
`endif

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic [30:0]  i_ext;
  logic [123:0] i_reg;
  logic         i_en;
  logic         i_IRQ;
  logic         o_IRQ;
  logic [4:0]   o_irq_addr;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  vic_irq_ctrl dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_ext      (i_ext),
    .i_reg      (i_reg),
    .i_en       (i_en),
    .i_IRQ      (i_IRQ),
    .o_IRQ      (o_IRQ),
    .o_irq_addr (o_irq_addr)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic irq, input logic [4:0] addr);
    check({tag, ".irq"},  32'(o_IRQ),      32'(irq));
    check({tag, ".addr"}, 32'(o_irq_addr), 32'(addr));
  endtask

  task automatic ack_pulse;
    i_IRQ = 1'b1;
    tick(1);
    i_IRQ = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    i_rst = 1'b1;
    i_ext = '0;
    i_reg = '0;
    i_en  = 1'b0;
    i_IRQ = 1'b0;
    tick(3);
    expect_out("reset_en0", 1'b0, 5'd31);

    i_reg = {108'b0, 16'b1000_1001_1010_1100};
    i_en  = 1'b1;
    #1;
    expect_out("reset_en1", 1'b0, 5'd31);
    i_rst = 1'b0;
    tick(LAT + 1);
    expect_out("idle", 1'b0, 5'd31);

    // Rising-edge source 1, then acknowledge.
    i_ext[1] = 1'b1;
    tick(LAT - 1);
    check("rise_latency", 32'(o_IRQ), 32'd0);
    tick(1);
    expect_out("rise_src1", 1'b1, 5'd1);
    ack_pulse();
    expect_out("ack_src1", 1'b0, 5'd31);

    // Level source 2: ack ignored, clears when input drops.
    i_ext[2] = 1'b1;
    tick(LAT);
    expect_out("level_src2", 1'b1, 5'd2);
    ack_pulse();
    expect_out("level_ack", 1'b1, 5'd2);
    i_ext[2] = 1'b0;
    tick(LAT - 1);
    check("level_drop_latency", 32'(o_IRQ), 32'd1);
    tick(1);
    expect_out("level_drop", 1'b0, 5'd31);

    // Falling-edge source 0 ignores a rise, pends on the fall.
    i_ext[0] = 1'b1;
    tick(LAT + 1);
    expect_out("fall_src0_rise", 1'b0, 5'd31);
    i_ext[0] = 1'b0;
    tick(LAT);
    expect_out("fall_src0", 1'b1, 5'd0);
    ack_pulse();
    expect_out("ack_src0", 1'b0, 5'd31);

    // Source 3 enabled with no mode never pends.
    i_ext[3] = 1'b1;
    tick(LAT + 1);
    expect_out("nomode_hi", 1'b0, 5'd31);
    i_ext[3] = 1'b0;
    tick(LAT + 1);
    expect_out("nomode_lo", 1'b0, 5'd31);

    // Priority: 1 and 2 together.
    i_ext[1] = 1'b0;
    tick(LAT + 1);
    expect_out("rise_src_fall_ignored", 1'b0, 5'd31);
    i_ext[1] = 1'b1;
    i_ext[2] = 1'b1;
    tick(LAT);
    expect_out("prio_1_2", 1'b1, 5'd1);
    ack_pulse();
    expect_out("prio_next", 1'b1, 5'd2);
    i_ext[2] = 1'b0;
    tick(LAT);
    expect_out("prio_clear", 1'b0, 5'd31);

    // Global enable gates outputs only; ack while gated is ignored.
    i_ext[1] = 1'b0;
    tick(LAT + 1);
    i_ext[1] = 1'b1;
    tick(LAT);
    expect_out("gate_pre", 1'b1, 5'd1);
    i_en = 1'b0;
    #1;
    expect_out("gate_off", 1'b0, 5'd31);
    ack_pulse();
    i_en = 1'b1;
    #1;
    expect_out("gate_on", 1'b1, 5'd1);

    // Ack coincident with a new edge on the same source: set wins.
    i_ext[1] = 1'b0;
    tick(LAT + 1);
    expect_out("hold_pend", 1'b1, 5'd1);
    i_ext[1] = 1'b1;
    tick(LAT - 1);
    ack_pulse();
    expect_out("ack_vs_edge", 1'b1, 5'd1);

    // Reset mid-pend clears everything; high input re-pends after release.
    i_ext[2] = 1'b1;
    i_rst    = 1'b1;
    tick(1);
    expect_out("reset_mid", 1'b0, 5'd31);
    tick(1);
    i_rst = 1'b0;
    tick(LAT);
    expect_out("post_reset_edge", 1'b1, 5'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vic_irq_ctrl.md
# vic_irq_ctrl

Vectored interrupt controller that aggregates 31 external interrupt sources into one CPU interrupt line plus a 5-bit vector address. Each source is individually enabled and configured for level, rising-edge or falling-edge detection by a packed configuration word supplied by the register block. The block sits between peripheral interrupt lines and the CPU core's IRQ input.

## Interface
- Parameters: none; source count (31) and widths are fixed package constants.
- Clocking: one clock; reset is synchronous and active-high.
- i_clk  in  1  system clock, all state on rising edge
- i_rst  in  1  synchronous active-high reset
- i_ext  in  31  external interrupt sources, bit k = source k, active-high
- i_reg  in  124  config, 4 bits per source: bits [4k+3:4k] = {en, fall, rise, level}
- i_en  in  1  global enable; 0 forces o_IRQ=0, o_irq_addr=31
- i_IRQ  in  1  CPU acknowledge; high at a clock edge clears the pending flag of the source at o_irq_addr
- o_IRQ  out  1  interrupt request to CPU
- o_irq_addr  out  5  highest-priority pending source index; 31 = none

## Operation
- Per source k: a history register holds the previous sample of i_ext[k].
- Mode select, by priority: level=1 → level mode; else rise and/or fall → edge mode (both set = any edge); none set → source never pends.
- Level mode: pending[k] = en & sampled i_ext[k] (tracks input; ack has no effect).
- Edge mode: pending[k] set on a detected selected edge when en=1; held until acknowledged.
- en=0 clears pending[k] and blocks setting.
- Priority: lowest index wins; o_irq_addr = lowest k with pending[k]; 31 when none pending or i_en=0.
- o_IRQ = i_en & (|pending). Outputs combinational from pending registers.
- Ack: i_IRQ=1 at an edge while o_IRQ=1 clears pending[o_irq_addr] (edge mode only). i_IRQ while o_IRQ=0 ignored.
- Simultaneous ack and new edge on same source: set wins (pending stays 1).
- i_en=0 only gates outputs; pending flags keep latching.

## Timing
- Reset: pending=0, history/sync regs=0, o_IRQ=0, o_irq_addr=31.
- History resets to 0, so an input already high after reset produces a rising edge.
- Without sync: i_ext change sampled at edge N, pending updates at edge N+1, outputs valid after N+1 (latency 2 edges).
- With sync: +1 edge (latency 3).
- Ack takes effect at the edge it is sampled; next-priority source appears on o_irq_addr same cycle after that edge.
- Reset mid-operation clears all pending regardless of inputs.

## Configuration
- VIC_IRQ_SYNC_EN defined: two-flop synchronizer on each i_ext bit before edge detection (for asynchronous sources).
- Not defined: single sample register; i_ext assumed synchronous to i_clk.

## Structure
- Package vic_irq_pkg: NUM_SRC=31, ADDR_W=5, NO_IRQ=5'd31, CFG_W=4, field offsets CFG_LEVEL=0, CFG_RISE=1, CFG_FALL=2, CFG_EN=3.
- Sub-module vic_irq_src: one source's sampling, edge detect, mode select and pending flag; instantiated 31 times via generate. Top holds priority encoder and ack decode.

## Test plan
- Config i_reg=16'b1000_1001_1010_1100 (src0 fall, src1 rise, src2 level, src3 enabled no mode), i_en=1: raise i_ext[1] → o_IRQ=1, o_irq_addr=1; pulse i_IRQ → o_IRQ=0, addr=31.
- Same config: i_ext[2] high → addr=2; pulse i_IRQ → still addr=2; drop i_ext[2] → o_IRQ=0 after latency.
- Same config: i_ext[0] 1→0 → addr=0; i_ext[3] toggled → never pends.
- Sources 1 and 2 pending together → addr=1; ack → addr=2.
- i_en=0 with src1 pending → o_IRQ=0, addr=31; i_en=1 → addr=1 restored.
- Ack cycle coincident with new rising edge on src1 → pending remains, o_IRQ stays 1; i_rst=1 mid-pend → o_IRQ=0, addr=31 next edge.
